// File: rtl/alu_ctrl_issue_pkg.sv
// rtl/alu_ctrl_issue_pkg.sv - ALU op codes, RV32I opcodes and decode record shared by ALU and issue logic
package alu_ctrl_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       src_b_imm;
    logic       take_on_zero;
    logic       is_branch;
    logic       illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // Shared funct3 table for OP and OP-IMM; alt selects SUB/SRA
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_issue_skid.sv
// rtl/alu_ctrl_issue_skid.sv - generic 2-entry valid/ready register slice (main + skid)
module alu_ctrl_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  logic             main_v, skid_v, ready_q;
  logic [WIDTH-1:0] main_d, skid_d;
  logic             push, pop;
  logic             main_v_n, skid_v_n;
  logic             load_main, load_skid, main_from_skid;

  assign push     = s_tvalid && ready_q;
  assign pop      = main_v && m_tready;
  assign s_tready = ready_q;
  assign m_tvalid = main_v;
  assign m_tdata  = main_d;

  always_comb begin
    main_v_n       = main_v;
    skid_v_n       = skid_v;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (pop) begin
      // When full, ready_q is low so push cannot coincide with a skid drain
      if (skid_v) begin
        main_from_skid = 1'b1;
        skid_v_n       = 1'b0;
      end else if (push) begin
        load_main = 1'b1;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (push) begin
      if (main_v) begin
        load_skid = 1'b1;
        skid_v_n  = 1'b1;
      end else begin
        load_main = 1'b1;
        main_v_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b0;
      main_d  <= '0;
      skid_d  <= '0;
    end else begin
      main_v  <= main_v_n;
      skid_v  <= skid_v_n;
      ready_q <= !skid_v_n;
      if (main_from_skid) main_d <= skid_d;
      else if (load_main) main_d <= s_tdata;
      if (load_skid) skid_d <= s_tdata;
    end
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - RV32I opcode/funct decode into alu_ctrl, staged through a 2-entry skid buffer
module alu_ctrl_issue
  import alu_ctrl_issue_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic             src_b_imm,
  output logic             take_on_zero,
  output logic             is_branch,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    dec_t d;
    d = '0;
    case (op)
      OPC_OP: begin
        d.alu_ctrl = arith_op(f3, f7);
        d.illegal  = f7 && (f3 != 3'b000) && (f3 != 3'b101);
      end
      OPC_OP_IMM: begin
        // funct7_5 is immediate payload except for shifts
        d.alu_ctrl  = arith_op(f3, f7 && (f3 == 3'b101));
        d.src_b_imm = 1'b1;
        d.illegal   = f7 && (f3 == 3'b001);
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_JAL: begin
        d.alu_ctrl  = ALU_ADD;
        d.src_b_imm = 1'b1;
      end
      OPC_BRANCH: begin
        d.is_branch = 1'b1;
        case (f3)
          3'b000:  begin d.alu_ctrl = ALU_SUB;  d.take_on_zero = 1'b1; end
          3'b001:  d.alu_ctrl = ALU_SUB;
          3'b100:  d.alu_ctrl = ALU_SLT;
          3'b101:  begin d.alu_ctrl = ALU_SLT;  d.take_on_zero = 1'b1; end
          3'b110:  d.alu_ctrl = ALU_SLTU;
          3'b111:  begin d.alu_ctrl = ALU_SLTU; d.take_on_zero = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [DEC_W+TAG_W-1:0] in_data, out_data;
  dec_t                   out_dec;

  assign in_data = {decode(opcode, funct3, funct7_5), in_tag};

  alu_ctrl_skid #(
    .WIDTH(DEC_W + TAG_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (in_valid),
    .s_tready (in_ready),
    .s_tdata  (in_data),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (out_data)
  );

  assign out_dec      = out_data[DEC_W+TAG_W-1:TAG_W];
  assign out_tag      = out_data[TAG_W-1:0];
  assign alu_ctrl     = out_dec.alu_ctrl;
  assign src_b_imm    = out_dec.src_b_imm;
  assign take_on_zero = out_dec.take_on_zero;
  assign is_branch    = out_dec.is_branch;
  assign illegal      = out_dec.illegal;

endmodule
